sipo_deser: RTL and testbench

- Serial-in parallel-out receiver: the receive end of the serial link driven by the team's parallel-in serial-out shift register.
- Samples one bit per enabled clock and assembles WIDTH-bit words.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Flags words lost to backpressure. Supports re-alignment of the bit counter via a sync strobe.

---
 rtl/sipo_deser_if.sv | 24 ++
 rtl/sipo_deser.sv | 73 +++++++
 tb/tb_sipo_deser.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deser_if.sv
// Serial receive link plus parallel word handshake for sipo_deser.
// valid/ready: a word transfers on a clk edge where pout_valid & pout_ready; pout is stable while pout_valid=1.
interface sipo_deser_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_en;
    logic             sync;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic             overrun;

    modport master (
        output sin, sin_en, sync, pout_ready,
        input  pout, pout_valid, busy, overrun
    );

    modport slave (
        input  sin, sin_en, sync, pout_ready,
        output pout, pout_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words from a bit stream
// and presents them on a registered valid/ready output, flagging dropped words.
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic         clk,
    input logic         rst,
    sipo_deser_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Only WIDTH-1 partial bits ever need storing; the last bit comes straight from sin.
    logic [WIDTH-2:0] shreg, shreg_base, shreg_nxt;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt, cnt_eff, cnt_nxt;
    logic             complete;
    logic             accept;
    logic [WIDTH-1:0] pout_q;
    logic             valid_q;
    logic             overrun_q;

    always_comb begin
        cnt_eff    = bus.sync ? '0 : cnt;
        shreg_base = bus.sync ? '0 : shreg;
        complete   = bus.sin_en && (cnt_eff == LAST);
        cnt_nxt    = cnt_eff;
        shreg_nxt  = shreg_base;
        if (MSB_FIRST) begin
            word = {shreg_base, bus.sin};
        end else begin
            word = {bus.sin, shreg_base};
        end
        if (bus.sin_en) begin
            shreg_nxt = MSB_FIRST ? word[WIDTH-2:0] : word[WIDTH-1:1];
            cnt_nxt   = complete ? '0 : cnt_eff + CW'(1);
        end
    end

    assign accept = valid_q & bus.pout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else begin
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    // A completed word may replace the held one only if it leaves this same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (complete && (!valid_q || accept)) begin
            pout_q  <= word;
            valid_q <= 1'b1;
        end else if (complete) begin
            overrun_q <= 1'b1;
        end else if (accept) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.pout       = pout_q;
    assign bus.pout_valid = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (cnt != '0);
endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: an MSB-first and an LSB-first instance share one stimulus stream
// and are checked against directed expectations and a bit-queue reference model.
module tb_sipo_deser;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(W)) bm ();
  sipo_deser_if #(.WIDTH(W)) bl ();

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm));
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl));

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int           bits_q[$];
  logic [W-1:0] exp_pout_m, exp_pout_l;
  logic         exp_valid, exp_overrun, exp_busy;

  task automatic model_step(input logic r, input logic s, input logic en,
                            input logic sy, input logic rdy);
    logic acc, done;
    logic [W-1:0] wm, wl;
    wm = '0;
    wl = '0;
    done = 1'b0;
    if (r) begin
      bits_q.delete();
      exp_pout_m = '0; exp_pout_l = '0;
      exp_valid = 1'b0; exp_overrun = 1'b0;
    end else begin
      acc = exp_valid && rdy;
      if (sy) bits_q.delete();
      if (en) begin
        bits_q.push_back(int'(s));
        if (bits_q.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            wm = wm | (W'(bits_q[i]) << (W - 1 - i));
            wl = wl | (W'(bits_q[i]) << i);
          end
          bits_q.delete();
        end
      end
      if (done && (!exp_valid || acc)) begin
        exp_pout_m = wm; exp_pout_l = wl; exp_valid = 1'b1;
      end else if (done) begin
        exp_overrun = 1'b1;
      end else if (acc) begin
        exp_valid = 1'b0;
      end
    end
    exp_busy = (bits_q.size() != 0);
  endtask

  // drive one cycle of inputs, advance the model at the edge, settle 1ns later
  task automatic cycle(input logic r, input logic s, input logic en,
                       input logic sy, input logic rdy);
    rst = r;
    bm.sin = s; bl.sin = s;
    bm.sin_en = en; bl.sin_en = en;
    bm.sync = sy; bl.sync = sy;
    bm.pout_ready = rdy; bl.pout_ready = rdy;
    @(posedge clk);
    model_step(r, s, en, sy, rdy);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({bm.pout, bm.pout_valid, bm.busy, bm.overrun} !== {4'b0000, 3'b000}) begin
      n_err++;
      $display("FAIL reset_m: got pout=%b v=%b busy=%b ovr=%b want all 0",
               bm.pout, bm.pout_valid, bm.busy, bm.overrun);
    end
    n_cmp++;
    if ({bl.pout, bl.pout_valid, bl.busy, bl.overrun} !== {4'b0000, 3'b000}) begin
      n_err++;
      $display("FAIL reset_l: got pout=%b v=%b busy=%b ovr=%b want all 0",
               bl.pout, bl.pout_valid, bl.busy, bl.overrun);
    end
  endtask

  task automatic test_basic();
    logic b[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, b[i], 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (bm.busy !== (i < 3)) begin
        n_err++;
        $display("FAIL basic_busy bit%0d: got %b want %b", i, bm.busy, (i < 3));
      end
      n_cmp++;
      if (bm.pout_valid !== (i == 3)) begin
        n_err++;
        $display("FAIL basic_valid bit%0d: got %b want %b", i, bm.pout_valid, (i == 3));
      end
    end
    n_cmp++;
    if (bm.pout !== 4'b1011) begin
      n_err++;
      $display("FAIL basic_msb_pout: got %b want 1011", bm.pout);
    end
    n_cmp++;
    if (bl.pout !== 4'b1101) begin
      n_err++;
      $display("FAIL basic_lsb_pout: got %b want 1101", bl.pout);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bm.pout_valid !== 1'b0 || bm.pout !== 4'b1011) begin
      n_err++;
      $display("FAIL basic_after_accept: got v=%b pout=%b want v=0 pout=1011",
               bm.pout_valid, bm.pout);
    end
  endtask

  task automatic test_gap();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (bm.busy !== 1'b1 || bm.pout_valid !== 1'b0) begin
        n_err++;
        $display("FAIL gap_hold%0d: got busy=%b v=%b want busy=1 v=0", i, bm.busy, bm.pout_valid);
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (bm.pout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL gap_early_valid: got %b want 0", bm.pout_valid);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (bm.pout_valid !== 1'b1 || bm.pout !== 4'b1100 || bl.pout !== 4'b0011) begin
      n_err++;
      $display("FAIL gap_word: got v=%b m=%b l=%b want v=1 m=1100 l=0011",
               bm.pout_valid, bm.pout, bl.pout);
    end
  endtask

  task automatic test_backpressure();
    logic b[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, b[i], 1'b1, 1'b0, 1'b0);
      if (i == 3 || i == 6) begin
        n_cmp++;
        if (bm.overrun !== 1'b0) begin
          n_err++;
          $display("FAIL bp_early_overrun bit%0d: got %b want 0", i, bm.overrun);
        end
      end
    end
    n_cmp++;
    if (bm.pout !== 4'b1011 || bm.pout_valid !== 1'b1 || bm.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL bp_drop: got pout=%b v=%b ovr=%b want 1011 1 1",
               bm.pout, bm.pout_valid, bm.overrun);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bm.pout_valid !== 1'b0 || bm.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got v=%b ovr=%b want 0 1", bm.pout_valid, bm.overrun);
    end
  endtask

  task automatic test_sync();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (bm.busy !== 1'b1 || bm.pout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sync_restart: got busy=%b v=%b want 1 0", bm.busy, bm.pout_valid);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (bm.pout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sync_no_early: got v=%b want 0", bm.pout_valid);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (bm.pout !== 4'b0110 || bm.pout_valid !== 1'b1 || bm.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL sync_word: got pout=%b v=%b ovr=%b want 0110 1 0",
               bm.pout, bm.pout_valid, bm.overrun);
    end
    // sync without enable just clears the partial word
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (bm.busy !== 1'b0) begin
      n_err++;
      $display("FAIL sync_idle_busy: got %b want 0", bm.busy);
    end
  endtask

  task automatic test_reset_mid();
    logic b[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({bm.pout, bm.pout_valid, bm.busy, bm.overrun} !== 7'b0) begin
      n_err++;
      $display("FAIL rstmid_clear: got pout=%b v=%b busy=%b ovr=%b want all 0",
               bm.pout, bm.pout_valid, bm.busy, bm.overrun);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, b[i], 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (bm.pout !== 4'b0011 || bm.pout_valid !== 1'b1 || bl.pout !== 4'b1100) begin
      n_err++;
      $display("FAIL rstmid_word: got m=%b v=%b l=%b want 0011 1 1100",
               bm.pout, bm.pout_valid, bl.pout);
    end
  endtask

  task automatic test_random();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      cycle(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 14) == 0),
            1'($urandom_range(0, 1)));
      n_cmp++;
      if (bm.pout_valid !== exp_valid || bm.busy !== exp_busy || bm.overrun !== exp_overrun) begin
        n_err++;
        $display("FAIL rand_ctrl_m c%0d: got v=%b busy=%b ovr=%b want %b %b %b", c,
                 bm.pout_valid, bm.busy, bm.overrun, exp_valid, exp_busy, exp_overrun);
      end
      n_cmp++;
      if (bl.pout_valid !== exp_valid || bl.busy !== exp_busy || bl.overrun !== exp_overrun) begin
        n_err++;
        $display("FAIL rand_ctrl_l c%0d: got v=%b busy=%b ovr=%b want %b %b %b", c,
                 bl.pout_valid, bl.busy, bl.overrun, exp_valid, exp_busy, exp_overrun);
      end
      n_cmp++;
      if (bm.pout !== exp_pout_m || bl.pout !== exp_pout_l) begin
        n_err++;
        $display("FAIL rand_pout c%0d: got m=%b l=%b want m=%b l=%b", c,
                 bm.pout, bl.pout, exp_pout_m, exp_pout_l);
      end
    end
  endtask

  initial begin
    bm.sin = 1'b0; bl.sin = 1'b0;
    bm.sin_en = 1'b0; bl.sin_en = 1'b0;
    bm.sync = 1'b0; bl.sync = 1'b0;
    bm.pout_ready = 1'b0; bl.pout_ready = 1'b0;
    test_reset();
    test_basic();
    test_gap();
    test_backpressure();
    test_sync();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
